// File: rtl/uart_rx_pkg.sv
// Shared UART receive configuration: parameter defaults and the receiver FSM state type.
package configure;
  localparam int clk_divider_slow = 10;
  localparam int clks_per_bit     = 85;
  localparam int buffer_depth     = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO for received UART data; head byte is presented combinationally, 0 when empty.
module uart_rx_fifo
  import configure::*;
#(
  parameter  int DEPTH = buffer_depth,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop frees the slot a same-cycle push needs when full
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: input synchroniser, slow-tick divider, frame FSM, sticky error flags, byte FIFO.
module uart_rx
  import configure::*;
#(
  parameter  int CLK_DIVIDER_SLOW = clk_divider_slow,
  parameter  int CLKS_PER_BIT     = clks_per_bit,
  parameter  int BUFFER_DEPTH     = buffer_depth,
  localparam int CW               = $clog2(BUFFER_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rx,
  input  logic          rx_pop,
  input  logic          err_clear,
  output logic          rx_valid,
  output logic [7:0]    rx_data,
  output logic [CW-1:0] rx_count,
  output logic          frame_err,
  output logic          overrun
);
  localparam int TW = (CLK_DIVIDER_SLOW > 1) ? $clog2(CLK_DIVIDER_SLOW) : 1;
  localparam int BW = (CLKS_PER_BIT > 0) ? $clog2(CLKS_PER_BIT + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIVIDER_SLOW - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_HALF  = BW'(CLKS_PER_BIT / 2);

  logic           rx_meta, rx_s, rx_prev, fall;
  logic [2:0]     vld_pipe;
  uart_rx_state_t state, state_nxt;
  logic [TW-1:0]  tick_cnt, tick_cnt_nxt;
  logic [BW-1:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]     idx, idx_nxt;
  logic [7:0]     shreg, shreg_nxt;
  logic           tick, push, ferr_set, ovr_set;
  logic           fifo_full, fifo_empty;

  // vld_pipe marks when rx_prev holds a real line sample rather than the reset preset,
  // so a line held low through reset release never looks like a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      vld_pipe <= '0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  assign fall = vld_pipe[2] & rx_prev & ~rx_s;
  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick ? '0 : tick_cnt + 1'b1;
    bit_cnt_nxt  = tick ? bit_cnt + 1'b1 : bit_cnt;
    idx_nxt      = idx;
    shreg_nxt    = shreg;
    push         = 1'b0;
    ferr_set     = 1'b0;
    unique case (state)
      IDLE: begin
        tick_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        if (fall) state_nxt = START;
      end
      START: if (tick && bit_cnt == BIT_HALF) begin
        bit_cnt_nxt = '0;
        idx_nxt     = '0;
        state_nxt   = rx_s ? IDLE : DATA;
      end
      DATA: if (tick && bit_cnt == BIT_LAST) begin
        bit_cnt_nxt     = '0;
        shreg_nxt[idx]  = rx_s;
        idx_nxt         = idx + 1'b1;
        if (idx == 3'd7) state_nxt = STOP;
      end
      STOP: if (tick && bit_cnt == BIT_LAST) begin
        // Leave at mid-stop-bit so the next start edge is not missed
        bit_cnt_nxt = '0;
        state_nxt   = IDLE;
        push        = rx_s;
        ferr_set    = ~rx_s;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ovr_set = push & fifo_full & ~rx_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      if (err_clear)     frame_err <= 1'b0;
      else if (ferr_set) frame_err <= 1'b1;
      if (err_clear)     overrun   <= 1'b0;
      else if (ovr_set)  overrun   <= 1'b1;
    end
  end

  uart_rx_fifo #(.DEPTH(BUFFER_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (shreg_nxt),
    .pop   (rx_pop),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  assign rx_valid = ~fifo_empty;
endmodule
